// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system ID word and the timestamp word
// and compares both against build-time expected values.
`default_nettype none

module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd588734791,
  parameter logic [31:0] EXPECTED_TS    = 32'd1376070339,
  parameter int          USE_RDV        = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t     state, next_state;
  logic       armed;
  logic [7:0] cnt;
  logic       in_rd, in_wt, accept, cap_id, cap_ts, expired;

  always_comb begin
    next_state = state;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    in_rd      = (state == RD_ID) || (state == RD_TS);
    in_wt      = (state == WT_ID) || (state == WT_TS);
    accept     = in_rd && !waitrequest;
    // Progress in the final counted cycle wins over the abort.
    expired    = ((in_rd && !accept) || (in_wt && !readdatavalid)) && (cnt >= TO_LIMIT);

    case (state)
      IDLE: begin
        if (start || armed) next_state = RD_ID;
      end
      RD_ID: begin
        if (accept) begin
          if (USE_RDV == 0) begin
            cap_id     = 1'b1;
            next_state = RD_TS;
          end else begin
            next_state = WT_ID;
          end
        end
      end
      WT_ID: begin
        if (readdatavalid) begin
          cap_id     = 1'b1;
          next_state = RD_TS;
        end
      end
      RD_TS: begin
        if (accept) begin
          if (USE_RDV == 0) begin
            cap_ts     = 1'b1;
            next_state = FIN;
          end else begin
            next_state = WT_TS;
          end
        end
      end
      WT_TS: begin
        if (readdatavalid) begin
          cap_ts     = 1'b1;
          next_state = FIN;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase

    if (expired) next_state = FIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Bus and status outputs are registered from the next state so that
  // waitrequest never reaches read/address combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed    <= (AUTO_START != 0);
      cnt      <= 8'd0;
      read     <= 1'b0;
      address  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      read    <= (next_state == RD_ID) || (next_state == RD_TS);
      address <= (next_state == RD_TS) || (next_state == WT_TS);
      busy    <= (next_state != IDLE);
      done    <= (next_state == FIN);

      if (state == IDLE && next_state == RD_ID) begin
        armed   <= 1'b0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end

      if ((next_state == RD_ID && state != RD_ID) || (next_state == RD_TS && state != RD_TS))
        cnt <= 8'd0;
      else if ((in_rd || in_wt) && cnt != 8'hFF)
        cnt <= cnt + 8'd1;

      if (cap_id)  id_value <= readdata;
      if (cap_ts)  ts_value <= readdata;
      if (expired) timeout  <= 1'b1;

      if (state == FIN) begin
        id_ok <= !timeout && (id_value == EXPECTED_ID);
        ts_ok <= !timeout && (ts_value == EXPECTED_TS);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: one zero-latency DUT and one readdatavalid DUT,
// each driven by a behavioural Avalon slave with configurable stalls and latency.
`default_nettype none

module tb_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'd588734791;
  localparam logic [31:0] EXP_TS = 32'd1376070339;
  localparam int          TO     = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [1:0]  rd, addr, busy, done, iok, tok, tmo;
  logic [1:0]  wreq = 2'b00;
  logic [1:0]  rdv = 2'b00;
  logic [31:0] rdata [2];
  logic [31:0] idv [2];
  logic [31:0] tsv [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .USE_RDV(0),
                  .TIMEOUT_CYCLES(TO), .AUTO_START(1)) dut0 (
    .clk(clk), .reset(rst), .start(start[0]), .address(addr[0]), .read(rd[0]),
    .readdata(rdata[0]), .waitrequest(wreq[0]), .readdatavalid(rdv[0]),
    .busy(busy[0]), .done(done[0]), .id_ok(iok[0]), .ts_ok(tok[0]), .timeout(tmo[0]),
    .id_value(idv[0]), .ts_value(tsv[0]));

  sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .USE_RDV(1),
                  .TIMEOUT_CYCLES(TO), .AUTO_START(1)) dut1 (
    .clk(clk), .reset(rst), .start(start[1]), .address(addr[1]), .read(rd[1]),
    .readdata(rdata[1]), .waitrequest(wreq[1]), .readdatavalid(rdv[1]),
    .busy(busy[1]), .done(done[1]), .id_ok(iok[1]), .ts_ok(tok[1]), .timeout(tmo[1]),
    .id_value(idv[1]), .ts_value(tsv[1]));

  typedef struct {
    int          cyc;
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        iok;
    logic        tok;
    logic        to;
  } exp_t;

  exp_t        expq [2][$];
  logic [31:0] mid [2];
  logic [31:0] mts [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  // Slave configuration and state
  logic [31:0] s_data [2][2];
  int          s_wait [2][2];
  int          s_lat  [2];
  int          s_stall[2];
  int          wcnt   [2] = '{0, 0};
  int          cdn    [2] = '{0, 0};
  logic [31:0] pdata  [2];
  logic [1:0]  pw = 2'b00, pa = 2'b00, pend = 2'b00;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && pw[d] && s_stall[d] < 0) begin
        chk("read_held_in_stall", d, rd[d], 1);
        chk("addr_held_in_stall", d, addr[d], pa[d]);
      end
      pw[d]    = 1'b0;
      wreq[d]  = 1'b0;
      rdv[d]   = 1'b0;
      rdata[d] = $urandom;
      if (pend[d]) begin
        cdn[d]--;
        if (cdn[d] == 0) begin
          pend[d]  = 1'b0;
          rdv[d]   = 1'b1;
          rdata[d] = pdata[d];
        end
      end
      if (rd[d] === 1'b1) begin
        if (s_stall[d] == int'(addr[d]) || wcnt[d] < s_wait[d][addr[d]]) begin
          wreq[d] = 1'b1;
          wcnt[d]++;
          pw[d]   = 1'b1;
          pa[d]   = addr[d];
        end else begin
          wcnt[d] = 0;
          if (d == 0) rdata[d] = s_data[d][addr[d]];
          else begin
            pend[d]  = 1'b1;
            cdn[d]   = s_lat[d];
            pdata[d] = s_data[d][addr[d]];
          end
        end
      end else begin
        wcnt[d] = 0;
      end
    end
  end

  // Monitor: pops one expectation per done pulse; flags are checked the cycle after.
  exp_t       cur [2];
  logic [1:0] okpend = 2'b00;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (okpend[d]) begin
        okpend[d] = 1'b0;
        chk("id_ok", d, iok[d], cur[d].iok);
        chk("ts_ok", d, tok[d], cur[d].tok);
      end
      if (done[d] === 1'b1) begin
        if (expq[d].size() == 0) begin
          chk("unexpected_done", d, done[d], 0);
        end else begin
          cur[d] = expq[d].pop_front();
          chk("done_cycle", d, cyc, cur[d].cyc);
          chk("id_value", d, idv[d], cur[d].idv);
          chk("ts_value", d, tsv[d], cur[d].tsv);
          chk("timeout", d, tmo[d], cur[d].to);
          chk("busy_at_done", d, busy[d], 1);
          okpend[d] = 1'b1;
        end
      end
    end
  end

  // Reference: a check started in cycle n finishes after two reads, each costing
  // one cycle plus its stall plus (with readdatavalid) the slave latency.
  // stall: 0 = none, 1 = ID read never accepted, 2 = TS read never accepted.
  task automatic push_expect(input int d, input int n, input int w0, input int w1,
                             input int l, input int stall);
    exp_t e;
    if (stall == 0) begin
      e.cyc = n + 3 + w0 + w1 + 2 * l;
      e.idv = s_data[d][0];
      e.tsv = s_data[d][1];
      e.iok = (e.idv == EXP_ID);
      e.tok = (e.tsv == EXP_TS);
      e.to  = 1'b0;
    end else begin
      e.to  = 1'b1;
      e.iok = 1'b0;
      e.tok = 1'b0;
      e.tsv = mts[d];
      e.idv = (stall == 2) ? s_data[d][0] : mid[d];
      e.cyc = (stall == 1) ? n + TO + 2 : n + 2 + w0 + l + TO + 1;
    end
    mid[d] = e.idv;
    mts[d] = e.tsv;
    expq[d].push_back(e);
  endtask

  task automatic wait_drain(input int d);
    for (int i = 0; i < 300 && expq[d].size() != 0; i++) @(negedge clk);
    if (expq[d].size() != 0) begin
      chk("done_never_seen", d, expq[d].size(), 0);
      expq[d].delete();
    end
  endtask

  task automatic run_check(input int d, input logic [31:0] idd, input logic [31:0] tsd,
                           input int w0, input int w1, input int l, input int stall,
                           input bit dup);
    s_data[d][0] = idd;
    s_data[d][1] = tsd;
    s_wait[d][0] = w0;
    s_wait[d][1] = w1;
    s_lat[d]     = l;
    s_stall[d]   = stall - 1;
    push_expect(d, cyc, w0, w1, l, stall);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    if (dup) begin
      @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
    end
    wait_drain(d);
    repeat (6) @(negedge clk);
    s_stall[d] = -1;
  endtask

  task automatic check_zero(input int d);
    chk("rst_read", d, rd[d], 0);
    chk("rst_address", d, addr[d], 0);
    chk("rst_busy", d, busy[d], 0);
    chk("rst_done", d, done[d], 0);
    chk("rst_id_ok", d, iok[d], 0);
    chk("rst_ts_ok", d, tok[d], 0);
    chk("rst_timeout", d, tmo[d], 0);
    chk("rst_id_value", d, idv[d], 0);
    chk("rst_ts_value", d, tsv[d], 0);
  endtask

  task automatic default_slave(input int d, input int l);
    s_data[d][0] = EXP_ID;
    s_data[d][1] = EXP_TS;
    s_wait[d][0] = 0;
    s_wait[d][1] = 0;
    s_lat[d]     = l;
    s_stall[d]   = -1;
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      default_slave(d, (d == 0) ? 0 : 2);
      mid[d] = '0;
      mts[d] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);

    // Auto-start after release on both instances
    for (int d = 0; d < 2; d++) push_expect(d, cyc, 0, 0, s_lat[d], 0);
    rst = 1'b0;
    wait_drain(0);
    wait_drain(1);
    repeat (4) @(negedge clk);

    run_check(0, EXP_ID, 32'h0, 0, 0, 0, 0, 1'b0);      // wrong timestamp
    run_check(0, EXP_ID, EXP_TS, 3, 3, 0, 0, 1'b0);     // 3 stall cycles on each read
    run_check(1, EXP_ID, EXP_TS, 0, 0, 2, 0, 1'b0);     // readdatavalid 2 cycles late
    run_check(0, EXP_ID, EXP_TS, 0, 0, 0, 1, 1'b0);     // ID read stuck -> timeout
    run_check(1, EXP_ID, EXP_TS, 1, 0, 1, 2, 1'b0);     // TS read stuck -> timeout
    run_check(0, EXP_ID, EXP_TS, 1, 1, 0, 0, 1'b1);     // start while busy is dropped
    run_check(1, 32'h1234_5678, EXP_TS, 2, 1, 3, 0, 1'b1);

    // Reset while dut1 waits for the timestamp data
    default_slave(0, 0);
    default_slave(1, 3);
    n = cyc;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    while (cyc < n + 7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero(1);
    chk("rst_id_value", 0, idv[0], 0);
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      mid[d] = '0;
      mts[d] = '0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) push_expect(d, cyc, 0, 0, s_lat[d], 0);
    rst = 1'b0;
    wait_drain(0);
    wait_drain(1);
    repeat (4) @(negedge clk);

    for (int it = 0; it < 24; it++) begin
      int          d, w0, w1, l, stall;
      logic [31:0] idd, tsd;
      d     = it % 2;
      idd   = ($urandom_range(2) == 0) ? $urandom : EXP_ID;
      tsd   = ($urandom_range(2) == 0) ? $urandom : EXP_TS;
      w0    = $urandom_range(3);
      w1    = $urandom_range(3);
      l     = (d == 1) ? $urandom_range(3, 1) : 0;
      stall = ($urandom_range(7) == 0) ? $urandom_range(2, 1) : 0;
      run_check(d, idd, tsd, w0, w1, l, stall, ($urandom_range(3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire
